// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared definitions.
// Opcode map, FSM states and default latencies.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_DIV_BUSY
  } mdu_state_e;

  function automatic logic op_is_multi(
    input logic [2:0] op
  );
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide.
// Signed division truncates toward zero; remainder follows dividend.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        b_zero;

  assign a_neg = is_signed & a[31];
  assign b_neg = is_signed & b[31];

  // low 64 bits of a sign-extended product are exact
  assign a_ext = {{32{a_neg}}, a};
  assign b_ext = {{32{b_neg}}, b};
  assign prod  = a_ext * b_ext;

  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == 32'd0);
  assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
  assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;

  assign quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem  = a_neg ? -r_mag : r_mag;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: HI/LO registers, busy timing, stall.
// Results land in HI/LO when the latency counter expires.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  mdu_state_e  state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;

  mdu_arith u_arith (
    .a         (rs_val),
    .b         (rt_val),
    .is_signed (~op[0]),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem)
  );

  assign is_mul  = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  | (op == OP_DIVU);
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);

  assign busy    = (state != ST_IDLE);
  assign stall   = md_req & (busy | (start & op_is_multi(op)));
  assign mdu_out = (op == OP_MFHI) ? hi : lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            unique case (1'b1)
              is_mul: begin
                state   <= ST_MUL_BUSY;
                cnt     <= MUL_LOAD;
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                pend_wr <= 1'b1;
              end
              is_div: begin
                state   <= ST_DIV_BUSY;
                cnt     <= DIV_LOAD;
                pend_hi <= rem;
                pend_lo <= quot;
                pend_wr <= (rt_val != 32'd0);
              end
              is_mthi: hi <= rs_val;
              is_mtlo: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_MUL_BUSY, ST_DIV_BUSY: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl.
// Reference model tracks remaining latency and applies results arithmetically.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_req;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int n_chk;
  int n_err;

  int          m_left;
  logic        m_wr;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        last_stall;
  int          busy_cnt;

  mdu_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .md_req  (md_req),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_wr   = 1'b0;
    m_hi   = '0;
    m_lo   = '0;
    p_hi   = '0;
    p_lo   = '0;
  endtask

  task automatic model_edge(
    input logic        st,
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint          sa;
    longint          sb;
    longint          sq;
    longint          sr;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (st) begin
      case (o)
        3'd0, 3'd1: begin
          if (o == 3'd0) p = 64'(sa * sb);
          else           p = {32'd0, a} * {32'd0, b};
          p_hi   = p[63:32];
          p_lo   = p[31:0];
          m_wr   = 1'b1;
          m_left = MC;
        end
        3'd2, 3'd3: begin
          m_wr   = (b != 0);
          m_left = DC;
          if (b != 0) begin
            if (o == 3'd2) begin
              sq = sa / sb;
              sr = sa % sb;
              p_lo = sq[31:0];
              p_hi = sr[31:0];
            end else begin
              p_lo = a / b;
              p_hi = a % b;
            end
          end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // one clock: drive at edge+1, check comb mid-cycle, check state after edge
  task automatic cyc(
    input logic        st,
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        mr
  );
    logic exp_busy;
    start  = st;
    op     = o;
    rs_val = a;
    rt_val = b;
    md_req = mr;
    #3;
    exp_busy = (m_left > 0);
    chk("stall", 32'(stall), 32'(mr & (exp_busy | (st & (o <= 3'd3)))));
    chk("mdu_out", mdu_out, (o == 3'd6) ? m_hi : m_lo);
    last_stall = stall;
    if (busy) busy_cnt++;
    @(posedge clk);
    model_edge(st, o, a, b);
    #1;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", 32'(busy), 32'(m_left > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int s_cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    n_chk  = 0;
    n_err  = 0;
    busy_cnt = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    rs_val = '0;
    rt_val = '0;
    md_req = 1'b0;
    model_reset();
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // MULT 3 * -2
    busy_cnt = 0;
    cyc(1'b1, 3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
    idle(MC + 1);
    chk("mult_busy_n", 32'(busy_cnt), 32'(MC));
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // DIVU 7/2
    busy_cnt = 0;
    cyc(1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
    idle(DC + 1);
    chk("divu_busy_n", 32'(busy_cnt), 32'(DC));
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    // DIV -7/2
    cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC + 1);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // divide by zero leaves HI/LO untouched
    cyc(1'b1, 3'd4, 32'h11, 32'd0, 1'b0);
    cyc(1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
    busy_cnt = 0;
    cyc(1'b1, 3'd2, 32'd5, 32'd0, 1'b0);
    idle(DC + 1);
    chk("div0_busy_n", 32'(busy_cnt), 32'(DC));
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // stall window and ignored start while busy
    s_cnt = 0;
    cyc(1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
    s_cnt += int'(last_stall);
    for (int i = 1; i <= 8; i++) begin
      cyc(i == 2, 3'd3, 32'd100, 32'd7, 1'b1);
      s_cnt += int'(last_stall);
    end
    chk("stall_n", 32'(s_cnt), 32'd6);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);

    // start in the cycle busy falls is dropped
    cyc(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    idle(MC - 1);
    cyc(1'b1, 3'd5, 32'h5555, 32'd0, 1'b0);
    chk("late_lo", lo, 32'd42);
    idle(2);

    // reset during DIV busy
    cyc(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
    idle(3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(DC + 2);
    chk("post_rst_lo", lo, 32'd0);

    // MTLO then MFLO
    cyc(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
    cyc(1'b1, 3'd7, 32'd0, 32'd0, 1'b1);
    chk("mflo_out", mdu_out, 32'hDEAD_BEEF);
    chk("mflo_stall", 32'(last_stall), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'($urandom_range(0, 20)) - 32'd10;
        rb = 32'($urandom_range(0, 6)) - 32'd3;
      end
      cyc($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
          ra, rb, 1'($urandom_range(0, 1)));
    end
    idle(DC + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal 1..15).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-005 start  in  1  E-stage MDU instruction valid this cycle.
REQ-006 op  in  3  MDU opcode: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
REQ-007 rs_val  in  32  operand A (dividend/multiplicand; MTHI/MTLO source).
REQ-008 rt_val  in  32  operand B (divisor/multiplier).
REQ-009 md_req  in  1  D-stage instruction is any MDU op.
REQ-010 busy  out  1  multi-cycle operation in progress.
REQ-011 stall  out  1  pipeline stall request to D stage.
REQ-012 hi  out  32  architectural HI register.
REQ-013 lo  out  32  architectural LO register.
REQ-014 mdu_out  out  32  read data for MFHI/MFLO.

Function
REQ-015 The block SHALL implement states IDLE, MUL_BUSY, DIV_BUSY.
REQ-016 In IDLE, start with op MULT/MULTU SHALL go to MUL_BUSY, load counter with MULT_CYCLES-1, and latch the 64-bit product (signed for MULT, unsigned for MULTU) into a pending register.
REQ-017 In IDLE, start with op DIV/DIVU SHALL go to DIV_BUSY, load counter with DIV_CYCLES-1, and latch quotient/remainder (signed truncating toward zero for DIV; remainder sign follows dividend) as pending.
REQ-018 busy SHALL be 1 for exactly N consecutive cycles following the start edge (N = MULT_CYCLES or DIV_CYCLES), decrementing the counter each cycle.
REQ-019 On the edge at which the counter is 0 in a busy state, HI SHALL take pending high word/remainder, LO pending low word/quotient, state returns to IDLE, busy falls.
REQ-020 Divisor 0 SHALL still occupy DIV_BUSY for DIV_CYCLES but leave HI and LO unchanged.
REQ-021 start with MTHI/MTLO in IDLE SHALL write rs_val to HI/LO on that edge, no busy.
REQ-022 start with MFHI/MFLO SHALL not change state; mdu_out SHALL combinationally equal hi when op=MFHI, else lo.
REQ-023 start while busy=1 SHALL be ignored (no state, counter or HI/LO change).
REQ-024 stall SHALL equal md_req & (busy | (start & op<=3)), combinational.
REQ-025 Start in the same cycle busy falls SHALL be ignored (busy still 1 that cycle) and is held off by stall.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, counter 0, pending 0, hi=0, lo=0, busy=0.
REQ-027 Reset mid-operation SHALL discard the pending result; HI/LO remain 0.
REQ-028 First start is accepted on the first rising edge after reset deasserts.

Structure
REQ-029 mdu_pkg SHALL hold the op encoding constants, state encoding and default cycle counts.
REQ-030 One combinational sub-module mdu_arith SHALL compute signed/unsigned 64-bit product and quotient/remainder; mdu_ctrl holds FSM, counter and registers.

Verification
REQ-031 MULT rs=3, rt=0xFFFFFFFE -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 DIVU 7/2 -> busy 10 cycles; HI=1, LO=3. DIV 0xFFFFFFF9/2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-033 DIV 5/0 with HI=0x11, LO=0x22 preloaded by MTHI/MTLO -> busy 10 cycles; HI=0x11, LO=0x22.
REQ-034 MULT start then md_req=1 for 8 cycles -> stall=1 during start cycle and 5 busy cycles, 0 afterwards; second start during busy ignored.
REQ-035 reset=0 asserted at busy cycle 3 of DIV -> busy=0, hi=lo=0 immediately, no later update.
REQ-036 MTLO rs=0xDEADBEEF then MFLO -> lo=0xDEADBEEF next edge, mdu_out=0xDEADBEEF, stall=0.
